// File: rtl/vx_gpu_ctl_unit.sv
// GPU-control request decoder: one register stage, 1-cycle warp-control pulse plus a commit record.
// Backpressure: request is accepted only while the commit slot is empty or draining this cycle.
module vx_gpu_ctl_unit #(
  parameter int NUM_THREADS  = 4,
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int UUID_BITS    = 44,
  parameter int NR_BITS      = 5,
  parameter int NW_BITS      = $clog2(NUM_WARPS),
  parameter int NT_BITS      = $clog2(NUM_THREADS),
  parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [UUID_BITS-1:0]      req_uuid,
  input  logic [NW_BITS-1:0]        req_wid,
  input  logic [NUM_THREADS-1:0]    req_tmask,
  input  logic [31:0]               req_PC,
  input  logic [31:0]               req_next_PC,
  input  logic [2:0]                req_op_type,
  input  logic [NT_BITS-1:0]        req_tid,
  input  logic [NUM_THREADS*32-1:0] req_rs1_data,
  input  logic [NUM_THREADS*32-1:0] req_rs2_data,
  input  logic [NR_BITS-1:0]        req_rd,
  input  logic                      req_wb,
  output logic                      req_ready,
  output logic                      wctl_valid,
  output logic [NW_BITS-1:0]        wctl_wid,
  output logic [2:0]                wctl_op,
  output logic [NUM_THREADS-1:0]    wctl_tmask,
  output logic [NUM_THREADS-1:0]    wctl_else_tmask,
  output logic                      wctl_diverged,
  output logic [31:0]               wctl_pc,
  output logic [NUM_WARPS-1:0]      wctl_wmask,
  output logic [NB_BITS-1:0]        wctl_bar_id,
  output logic [NW_BITS-1:0]        wctl_bar_size_m1,
  output logic                      commit_valid,
  output logic [UUID_BITS-1:0]      commit_uuid,
  output logic [NW_BITS-1:0]        commit_wid,
  output logic [NUM_THREADS-1:0]    commit_tmask,
  output logic [31:0]               commit_PC,
  output logic [NR_BITS-1:0]        commit_rd,
  output logic                      commit_wb,
  input  logic                      commit_ready
);

  localparam logic [2:0] OP_TMC    = 3'd0;
  localparam logic [2:0] OP_WSPAWN = 3'd1;
  localparam logic [2:0] OP_SPLIT  = 3'd2;
  localparam logic [2:0] OP_JOIN   = 3'd3;
  localparam logic [2:0] OP_BAR    = 3'd4;
  localparam logic [2:0] OP_PRED   = 3'd5;

  logic [31:0]            rs1_lane [NUM_THREADS];
  logic [31:0]            rs2_lane [NUM_THREADS];
  logic [NUM_THREADS-1:0] lane_nz;
  logic [31:0]            s1, s2;
  logic [NUM_THREADS-1:0] taken, not_taken;
  logic                   fire;
  logic                   unused_wb;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_lane
    assign rs1_lane[i] = req_rs1_data[32*i +: 32];
    assign rs2_lane[i] = req_rs2_data[32*i +: 32];
    assign lane_nz[i]  = |req_rs1_data[32*i +: 32];
  end

  assign s1        = rs1_lane[req_tid];
  assign s2        = rs2_lane[req_tid];
  assign taken     = req_tmask & lane_nz;
  assign not_taken = req_tmask & ~lane_nz;
  assign unused_wb = req_wb;

  assign req_ready = ~commit_valid | commit_ready;
  assign fire      = req_valid & req_ready;

  logic                   wvld_d, div_d;
  logic [2:0]             wop_d;
  logic [NW_BITS-1:0]     wwid_d, bsz_d;
  logic [NUM_THREADS-1:0] tmask_d, else_d;
  logic [31:0]            pc_d;
  logic [NUM_WARPS-1:0]   wmask_d;
  logic [NB_BITS-1:0]     bar_d;

  always_comb begin
    wvld_d  = 1'b0;
    wop_d   = '0;
    wwid_d  = '0;
    tmask_d = '0;
    else_d  = '0;
    div_d   = 1'b0;
    pc_d    = '0;
    wmask_d = '0;
    bar_d   = '0;
    bsz_d   = '0;
    case (req_op_type)
      OP_TMC: begin
        wvld_d  = 1'b1;
        tmask_d = s1[NUM_THREADS-1:0];
      end
      OP_WSPAWN: begin
        wvld_d = 1'b1;
        // Warp 0 is the spawner; warps 1..s1-1 start, capped at NUM_WARPS.
        for (int w = 1; w < NUM_WARPS; w++) wmask_d[w] = (s1 > 32'(w));
        pc_d = s2;
      end
      OP_SPLIT: begin
        wvld_d = 1'b1;
        pc_d   = req_next_PC;
        if ((taken != '0) && (not_taken != '0)) begin
          div_d   = 1'b1;
          tmask_d = taken;
          else_d  = not_taken;
        end else begin
          tmask_d = req_tmask;
        end
      end
      OP_JOIN: wvld_d = 1'b1;
      OP_BAR: begin
        wvld_d = 1'b1;
        bar_d  = s1[NB_BITS-1:0];
        bsz_d  = s2[NW_BITS-1:0] - NW_BITS'(1);
      end
      OP_PRED: begin
        wvld_d  = 1'b1;
        // An all-false predicate would strand the warp, so keep the original mask.
        tmask_d = (taken != '0) ? taken : req_tmask;
      end
      default: ;
    endcase
    if (wvld_d) begin
      wop_d  = req_op_type;
      wwid_d = req_wid;
    end
  end

  logic                   wvld_q, div_q, cvld_q;
  logic [2:0]             wop_q;
  logic [NW_BITS-1:0]     wwid_q, bsz_q, cwid_q;
  logic [NUM_THREADS-1:0] tmask_q, else_q, ctmask_q;
  logic [31:0]            pc_q, cpc_q;
  logic [NUM_WARPS-1:0]   wmask_q;
  logic [NB_BITS-1:0]     bar_q;
  logic [UUID_BITS-1:0]   cuuid_q;
  logic [NR_BITS-1:0]     crd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wvld_q <= 1'b0; div_q <= 1'b0; cvld_q <= 1'b0;
      wop_q <= '0; wwid_q <= '0; bsz_q <= '0; cwid_q <= '0;
      tmask_q <= '0; else_q <= '0; ctmask_q <= '0;
      pc_q <= '0; cpc_q <= '0; wmask_q <= '0; bar_q <= '0;
      cuuid_q <= '0; crd_q <= '0;
    end else begin
      wvld_q <= fire & wvld_d;
      if (fire) begin
        cvld_q   <= 1'b1;
        wop_q    <= wop_d;
        wwid_q   <= wwid_d;
        tmask_q  <= tmask_d;
        else_q   <= else_d;
        div_q    <= div_d;
        pc_q     <= pc_d;
        wmask_q  <= wmask_d;
        bar_q    <= bar_d;
        bsz_q    <= bsz_d;
        cuuid_q  <= req_uuid;
        cwid_q   <= req_wid;
        ctmask_q <= req_tmask;
        cpc_q    <= req_PC;
        crd_q    <= req_rd;
      end else if (commit_ready) begin
        cvld_q <= 1'b0;
      end
    end
  end

  assign wctl_valid       = wvld_q;
  assign wctl_wid         = wwid_q;
  assign wctl_op          = wop_q;
  assign wctl_tmask       = tmask_q;
  assign wctl_else_tmask  = else_q;
  assign wctl_diverged    = div_q;
  assign wctl_pc          = pc_q;
  assign wctl_wmask       = wmask_q;
  assign wctl_bar_id      = bar_q;
  assign wctl_bar_size_m1 = bsz_q;
  assign commit_valid     = cvld_q;
  assign commit_uuid      = cuuid_q;
  assign commit_wid       = cwid_q;
  assign commit_tmask     = ctmask_q;
  assign commit_PC        = cpc_q;
  assign commit_rd        = crd_q;
  assign commit_wb        = 1'b0;

endmodule

// File: tb/tb_vx_gpu_ctl_unit.sv
// Bench for vx_gpu_ctl_unit: directed vector table, backpressure/reset sequences, random vs. model.
module tb_vx_gpu_ctl_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [43:0]  req_uuid;
  logic [1:0]   req_wid;
  logic [3:0]   req_tmask;
  logic [31:0]  req_PC, req_next_PC;
  logic [2:0]   req_op_type;
  logic [1:0]   req_tid;
  logic [127:0] req_rs1_data, req_rs2_data;
  logic [4:0]   req_rd;
  logic         req_wb;
  logic         req_ready;
  logic         wctl_valid;
  logic [1:0]   wctl_wid;
  logic [2:0]   wctl_op;
  logic [3:0]   wctl_tmask, wctl_else_tmask;
  logic         wctl_diverged;
  logic [31:0]  wctl_pc;
  logic [3:0]   wctl_wmask;
  logic [1:0]   wctl_bar_id, wctl_bar_size_m1;
  logic         commit_valid;
  logic [43:0]  commit_uuid;
  logic [1:0]   commit_wid;
  logic [3:0]   commit_tmask;
  logic [31:0]  commit_PC;
  logic [4:0]   commit_rd;
  logic         commit_wb;
  logic         commit_ready;

  vx_gpu_ctl_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_uuid(req_uuid), .req_wid(req_wid),
    .req_tmask(req_tmask), .req_PC(req_PC), .req_next_PC(req_next_PC), .req_op_type(req_op_type),
    .req_tid(req_tid), .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data), .req_rd(req_rd),
    .req_wb(req_wb), .req_ready(req_ready), .wctl_valid(wctl_valid), .wctl_wid(wctl_wid),
    .wctl_op(wctl_op), .wctl_tmask(wctl_tmask), .wctl_else_tmask(wctl_else_tmask),
    .wctl_diverged(wctl_diverged), .wctl_pc(wctl_pc), .wctl_wmask(wctl_wmask),
    .wctl_bar_id(wctl_bar_id), .wctl_bar_size_m1(wctl_bar_size_m1), .commit_valid(commit_valid),
    .commit_uuid(commit_uuid), .commit_wid(commit_wid), .commit_tmask(commit_tmask),
    .commit_PC(commit_PC), .commit_rd(commit_rd), .commit_wb(commit_wb), .commit_ready(commit_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // wctl bundle: {op, wid, tmask, else, diverged, pc, wmask, bar_id, bar_size_m1}
  logic [53:0] dut_w;
  logic [43:0] dut_c;
  assign dut_w = {wctl_op, wctl_wid, wctl_tmask, wctl_else_tmask, wctl_diverged, wctl_pc,
                  wctl_wmask, wctl_bar_id, wctl_bar_size_m1};
  assign dut_c = {commit_wid, commit_tmask, commit_PC, commit_rd, commit_wb};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [53:0] wpack(input logic [2:0] op, input logic [1:0] wid,
      input logic [3:0] tm, input logic [3:0] el, input logic dv, input logic [31:0] pc,
      input logic [3:0] wm, input logic [1:0] bid, input logic [1:0] bsz);
    return {op, wid, tm, el, dv, pc, wm, bid, bsz};
  endfunction

  function automatic logic [127:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference: {wctl_valid, wctl bundle} from the op rules, using whole-mask arithmetic.
  function automatic logic [54:0] model(input logic [2:0] op, input logic [1:0] wid,
      input logic [1:0] tid, input logic [3:0] tm, input logic [127:0] r1,
      input logic [127:0] r2, input logic [31:0] npc);
    logic [31:0] s1, s2, pc;
    logic [3:0]  c, t, e, wm, tk, el;
    logic        d;
    logic [1:0]  bid, bsz;
    longint      k;
    s1 = r1[32*int'(tid) +: 32];
    s2 = r2[32*int'(tid) +: 32];
    for (int i = 0; i < 4; i++) c[i] = (r1[32*i +: 32] != 0);
    t = 0; e = 0; d = 0; pc = 0; wm = 0; bid = 0; bsz = 0;
    if (op > 3'd5) return '0;
    case (op)
      3'd0: t = s1[3:0];
      3'd1: begin
        k  = (s1 > 4) ? 4 : longint'(s1);
        wm = 4'(((64'd1 << k) - 1) & 64'hE);
        pc = s2;
      end
      3'd2: begin
        tk = tm & c; el = tm & ~c; pc = npc;
        if (tk != 0 && el != 0) begin t = tk; e = el; d = 1; end
        else t = tm;
      end
      3'd4: begin
        bid = 2'(s1 % 4);
        bsz = 2'((s2 % 4 + 3) % 4);
      end
      3'd5: t = ((tm & c) != 0) ? (tm & c) : tm;
      default: ;
    endcase
    return {1'b1, wpack(op, wid, t, e, d, pc, wm, bid, bsz)};
  endfunction

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   wid;
    logic [1:0]   tid;
    logic [3:0]   tmask;
    logic [127:0] rs1;
    logic [127:0] rs2;
    logic [31:0]  npc;
    logic         exp_v;
    logic [53:0]  exp_w;
  } vec_t;

  logic [43:0] exp_uuid;
  logic [43:0] exp_c;

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_op_type  = v.op;
    req_wid      = v.wid;
    req_tid      = v.tid;
    req_tmask    = v.tmask;
    req_rs1_data = v.rs1;
    req_rs2_data = v.rs2;
    req_next_PC  = v.npc;
    req_uuid     = 44'({$urandom, $urandom});
    req_PC       = $urandom;
    req_rd       = 5'($urandom);
    req_wb       = 1'b1;
    exp_uuid     = req_uuid;
    exp_c        = {req_wid, req_tmask, req_PC, req_rd, 1'b0};
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 2))
      0:       return 32'd0;
      1:       return $urandom_range(0, 6);
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[14];

  initial begin
    logic        m_cv, m_wv, fire;
    logic [53:0] m_w;
    logic [54:0] mo;
    logic [43:0] m_uuid, m_c, u1, c1;

    vt[0]  = '{3'd0, 2'd2, 2'd1, 4'b1111, lanes(0, 5, 0, 0), '0, 32'h100, 1,
               wpack(0, 2, 4'b0101, 0, 0, 0, 0, 0, 0)};
    vt[1]  = '{3'd1, 2'd0, 2'd0, 4'b0001, lanes(3, 0, 0, 0), lanes(32'h8000_0100, 0, 0, 0), 32'h104, 1,
               wpack(1, 0, 0, 0, 0, 32'h8000_0100, 4'b0110, 0, 0)};
    vt[2]  = '{3'd1, 2'd1, 2'd3, 4'b1000, lanes(0, 0, 0, 9), lanes(0, 0, 0, 32'h2000), 32'h108, 1,
               wpack(1, 1, 0, 0, 0, 32'h2000, 4'b1110, 0, 0)};
    vt[3]  = '{3'd1, 2'd0, 2'd0, 4'b0001, lanes(1, 0, 0, 0), lanes(32'h40, 0, 0, 0), 32'h10c, 1,
               wpack(1, 0, 0, 0, 0, 32'h40, 4'b0000, 0, 0)};
    vt[4]  = '{3'd2, 2'd3, 2'd0, 4'b1111, lanes(1, 0, 1, 0), '0, 32'h1234, 1,
               wpack(2, 3, 4'b0101, 4'b1010, 1, 32'h1234, 0, 0, 0)};
    vt[5]  = '{3'd2, 2'd0, 2'd0, 4'b1111, lanes(1, 1, 1, 1), '0, 32'h2000, 1,
               wpack(2, 0, 4'b1111, 4'b0000, 0, 32'h2000, 0, 0, 0)};
    vt[6]  = '{3'd4, 2'd1, 2'd2, 4'b0100, lanes(0, 0, 2, 0), lanes(0, 0, 4, 0), 32'h110, 1,
               wpack(4, 1, 0, 0, 0, 0, 0, 2, 3)};
    vt[7]  = '{3'd5, 2'd2, 2'd0, 4'b1011, '0, '0, 32'h114, 1,
               wpack(5, 2, 4'b1011, 0, 0, 0, 0, 0, 0)};
    vt[8]  = '{3'd5, 2'd0, 2'd1, 4'b1011, lanes(0, 7, 0, 1), '0, 32'h118, 1,
               wpack(5, 0, 4'b1010, 0, 0, 0, 0, 0, 0)};
    vt[9]  = '{3'd0, 2'd1, 2'd0, 4'b1111, lanes(32'hFFFF_FFF0, 0, 0, 0), '0, 32'h11c, 1,
               wpack(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0)};
    vt[10] = '{3'd3, 2'd3, 2'd1, 4'b0110, lanes(1, 2, 3, 4), lanes(5, 6, 7, 8), 32'h120, 1,
               wpack(3, 3, 0, 0, 0, 0, 0, 0, 0)};
    vt[11] = '{3'd6, 2'd2, 2'd0, 4'b1111, lanes(3, 3, 3, 3), lanes(4, 4, 4, 4), 32'h124, 0, '0};
    vt[12] = '{3'd2, 2'd1, 2'd1, 4'b0110, lanes(1, 1, 1, 0), '0, 32'h3000, 1,
               wpack(2, 1, 4'b0110, 4'b0000, 0, 32'h3000, 0, 0, 0)};
    vt[13] = '{3'd4, 2'd0, 2'd0, 4'b0001, lanes(7, 0, 0, 0), lanes(1, 0, 0, 0), 32'h128, 1,
               wpack(4, 0, 0, 0, 0, 0, 0, 3, 0)};

    reset = 1'b1; req_valid = 1'b0; req_uuid = '0; req_wid = '0; req_tmask = '0;
    req_PC = '0; req_next_PC = '0; req_op_type = '0; req_tid = '0;
    req_rs1_data = '0; req_rs2_data = '0; req_rd = '0; req_wb = 1'b0; commit_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst commit_valid", 64'(commit_valid), 0);
    chk("rst wctl_valid", 64'(wctl_valid), 0);
    chk("rst req_ready", 64'(req_ready), 1);
    chk("rst wctl payload", 64'(dut_w), 0);
    chk("rst commit_uuid", 64'(commit_uuid), 0);
    chk("rst commit payload", 64'(dut_c), 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i]);
      commit_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d wctl_valid", i), 64'(wctl_valid), 64'(vt[i].exp_v));
      chk($sformatf("vec%0d wctl", i), 64'(dut_w), 64'(vt[i].exp_w));
      chk($sformatf("vec%0d commit_valid", i), 64'(commit_valid), 1);
      chk($sformatf("vec%0d commit_uuid", i), 64'(commit_uuid), 64'(exp_uuid));
      chk($sformatf("vec%0d commit", i), 64'(dut_c), 64'(exp_c));
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d wctl_pulse_end", i), 64'(wctl_valid), 0);
      chk($sformatf("vec%0d commit_drained", i), 64'(commit_valid), 0);
    end

    // Backpressure: hold three cycles, then drain and refill in one cycle.
    @(negedge clk);
    drive(vt[0]);
    commit_ready = 1'b1;
    @(negedge clk);
    u1 = exp_uuid; c1 = exp_c;
    chk("bp first wctl_valid", 64'(wctl_valid), 1);
    chk("bp first commit_valid", 64'(commit_valid), 1);
    drive(vt[4]);
    commit_ready = 1'b0;
    #1 chk("bp req_ready low", 64'(req_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d wctl_valid", i), 64'(wctl_valid), 0);
      chk($sformatf("bp hold%0d commit_valid", i), 64'(commit_valid), 1);
      chk($sformatf("bp hold%0d uuid", i), 64'(commit_uuid), 64'(u1));
      chk($sformatf("bp hold%0d commit", i), 64'(dut_c), 64'(c1));
      chk($sformatf("bp hold%0d wctl", i), 64'(dut_w), 64'(vt[0].exp_w));
      chk($sformatf("bp hold%0d req_ready", i), 64'(req_ready), 0);
    end
    commit_ready = 1'b1;
    #1 chk("bp drain req_ready", 64'(req_ready), 1);
    @(negedge clk);
    chk("bp second wctl_valid", 64'(wctl_valid), 1);
    chk("bp second wctl", 64'(dut_w), 64'(vt[4].exp_w));
    chk("bp second commit_valid", 64'(commit_valid), 1);
    chk("bp second uuid", 64'(commit_uuid), 64'(exp_uuid));
    chk("bp second commit", 64'(dut_c), 64'(exp_c));
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp end commit_valid", 64'(commit_valid), 0);
    chk("bp end wctl_valid", 64'(wctl_valid), 0);

    // Reset while a commit is pending discards it.
    drive(vt[6]);
    commit_ready = 1'b0;
    @(negedge clk);
    chk("mid-rst pending", 64'(commit_valid), 1);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid-rst commit_valid", 64'(commit_valid), 0);
    chk("mid-rst wctl_valid", 64'(wctl_valid), 0);
    chk("mid-rst req_ready", 64'(req_ready), 1);
    chk("mid-rst commit payload", 64'(dut_c), 0);

    // Random traffic against the transaction-level model.
    m_cv = 1'b0; m_wv = 1'b0; m_w = '0; m_uuid = '0; m_c = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      chk("rnd commit_valid", 64'(commit_valid), 64'(m_cv));
      if (m_cv) begin
        chk("rnd commit_uuid", 64'(commit_uuid), 64'(m_uuid));
        chk("rnd commit", 64'(dut_c), 64'(m_c));
      end
      chk("rnd wctl_valid", 64'(wctl_valid), 64'(m_wv));
      if (m_wv) chk("rnd wctl", 64'(dut_w), 64'(m_w));
      req_valid    = ($urandom_range(0, 3) != 0);
      req_op_type  = 3'($urandom_range(0, 7));
      req_wid      = 2'($urandom);
      req_tid      = 2'($urandom);
      req_tmask    = 4'($urandom);
      req_rs1_data = lanes(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      req_rs2_data = lanes(rnd_word(), rnd_word(), rnd_word(), rnd_word());
      req_PC       = $urandom;
      req_next_PC  = $urandom;
      req_uuid     = 44'({$urandom, $urandom});
      req_rd       = 5'($urandom);
      req_wb       = 1'($urandom);
      commit_ready = ($urandom_range(0, 3) != 0);
      #1 chk("rnd req_ready", 64'(req_ready), 64'(!m_cv || commit_ready));
      fire = req_valid && (!m_cv || commit_ready);
      mo = model(req_op_type, req_wid, req_tid, req_tmask, req_rs1_data, req_rs2_data, req_next_PC);
      if (fire) begin
        m_cv   = 1'b1;
        m_uuid = req_uuid;
        m_c    = {req_wid, req_tmask, req_PC, req_rd, 1'b0};
        m_wv   = mo[54];
        m_w    = mo[53:0];
      end else begin
        m_wv = 1'b0;
        if (commit_ready) m_cv = 1'b0;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vx_gpu_ctl_unit.md
Name: vx_gpu_ctl_unit

Overview:
Consumer of the GPU-control request channel (tmc/wspawn/split/join/bar/pred) issued by dispatch. Decodes each request, registers it in one output stage, and emits a one-cycle warp-control command to the warp scheduler. It also emits a commit record to writeback under valid/ready backpressure.

Parameters:
NUM_THREADS, 4, threads per warp
NUM_WARPS, 4, warps per core
NUM_BARRIERS, 4, hardware barriers
UUID_BITS, 44, instruction uuid width
NR_BITS, 5, register index width
NW_BITS, clog2(NUM_WARPS), warp id width
NT_BITS, clog2(NUM_THREADS), thread id width
NB_BITS, clog2(NUM_BARRIERS), barrier id width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_uuid  in  UUID_BITS  instruction uuid
req_wid  in  NW_BITS  warp id
req_tmask  in  NUM_THREADS  active mask
req_PC  in  32  instruction PC
req_next_PC  in  32  fall-through PC
req_op_type  in  3  0=TMC 1=WSPAWN 2=SPLIT 3=JOIN 4=BAR 5=PRED
req_tid  in  NT_BITS  leading active thread
req_rs1_data  in  NUM_THREADS*32  operand 1 per thread
req_rs2_data  in  NUM_THREADS*32  operand 2 per thread
req_rd  in  NR_BITS  destination register
req_wb  in  1  writeback enable
req_ready  out  1  request accepted when valid&ready
wctl_valid  out  1  one-cycle warp-control pulse
wctl_wid  out  NW_BITS  target warp
wctl_op  out  3  decoded op (same encoding)
wctl_tmask  out  NUM_THREADS  new mask (TMC/PRED), taken mask (SPLIT)
wctl_else_tmask  out  NUM_THREADS  SPLIT not-taken mask
wctl_diverged  out  1  SPLIT diverged flag
wctl_pc  out  32  WSPAWN start PC; SPLIT reconvergence PC (=next_PC)
wctl_wmask  out  NUM_WARPS  WSPAWN warps to activate
wctl_bar_id  out  NB_BITS  barrier id
wctl_bar_size_m1  out  NW_BITS  barrier participant count minus 1
commit_valid  out  1  commit record valid
commit_uuid  out  UUID_BITS  uuid
commit_wid  out  NW_BITS  warp id
commit_tmask  out  NUM_THREADS  original request tmask
commit_PC  out  32  PC
commit_rd  out  NR_BITS  rd
commit_wb  out  1  always 0 (control ops write nothing)
commit_ready  in  1  writeback accepts commit

Behaviour:
- req_ready = ~commit_valid | commit_ready (combinational, one-entry stage; full throughput when commit_ready held high).
- On fire (req_valid&req_ready): decode and load registers. Next cycle: commit_valid=1, wctl_valid=1 for exactly one cycle regardless of commit_ready.
- commit_valid holds, with payload stable, until commit_valid&commit_ready. Simultaneous drain and new fire: register reloads, commit_valid stays 1, wctl pulses again.
- Scalar source s1/s2 = lane req_tid of rs1/rs2.
- TMC: tmask = s1[NUM_THREADS-1:0]. Zero mask is legal and halts the warp.
- WSPAWN: n = s1. wmask bit w = (w>=1 && w<n) for w in 0..NUM_WARPS-1; n>NUM_WARPS saturates; n<=1 gives 0. pc = s2.
- SPLIT: per lane c=rs1[i]!=0. taken = tmask&c, else = tmask&~c. diverged = (taken!=0)&&(else!=0). If not diverged: tmask=req_tmask, else=0.
- JOIN: op/wid only; other wctl fields 0.
- BAR: bar_id = s1[NB_BITS-1:0]; bar_size_m1 = s2[NW_BITS-1:0]-1 (mod 2^NW_BITS).
- PRED: p = tmask & {rs1[i]!=0}. tmask = p if p!=0, else req_tmask.
- Op codes 6/7: commit only, wctl_valid stays 0.
- Unused wctl fields are 0 for each op.
- Reset: commit_valid=0, wctl_valid=0, all wctl/commit payloads 0, req_ready=1 in the first cycle after reset. Reset mid-hold discards the pending commit.

Test Plan:
- TMC wid=2, tid=1, rs1[1]=0x5 -> next cycle wctl_valid=1 op=0 wid=2 tmask=0101; commit_valid=1 wb=0; wctl_valid=0 the following cycle.
- WSPAWN s1=3, s2=0x8000_0100 -> wmask=0110, pc=0x80000100; s1=9 -> wmask=1110; s1=1 -> 0000.
- SPLIT tmask=1111, rs1 lanes={1,0,1,0} -> taken=0101, else=1010, diverged=1, pc=next_PC; lanes all 1 -> diverged=0, tmask=1111, else=0000.
- BAR s1=2, s2=4 -> bar_id=2, bar_size_m1=3. PRED with all-zero rs1, tmask=1011 -> tmask=1011.
- Backpressure: commit_ready=0 for 3 cycles after a fire -> req_ready=0, payload stable, single wctl pulse. commit_ready=1 with a new req the same cycle -> back-to-back commits, second wctl pulse.
- Assert reset while commit_valid=1 -> next cycle commit_valid=0, wctl_valid=0, req_ready=1.
